// File: rtl/ddr_burst_reader.sv
// rtl/ddr_burst_reader.sv - AXI4 burst read master with FWFT buffer feeding an AXIS output
module ddr_burst_reader #(
    parameter int ID_WIDTH       = 1,
    parameter int DATA_WIDTH     = 64,
    parameter int BURST_LENGTH   = 7,
    parameter int B_BURST_LENGTH = 8
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    // control block registers
    input  logic                      RSTART_REG,
    input  logic [31:0]               RADDR_REG,
    input  logic [31:0]               RLENGTH_REG,
    output logic                      RIDLE_REG,
    output logic                      RERR_REG,
    // AXI4 read address channel
    output logic [ID_WIDTH-1:0]       m_axi_arid,
    output logic [31:0]               m_axi_araddr,
    output logic [B_BURST_LENGTH-1:0] m_axi_arlen,
    output logic [2:0]                m_axi_arsize,
    output logic [1:0]                m_axi_arburst,
    output logic                      m_axi_arlock,
    output logic [3:0]                m_axi_arcache,
    output logic [2:0]                m_axi_arprot,
    output logic [3:0]                m_axi_arregion,
    output logic [3:0]                m_axi_arqos,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,
    // AXI4 read data channel
    input  logic [ID_WIDTH-1:0]       m_axi_rid,
    input  logic [DATA_WIDTH-1:0]     m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rlast,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready,
    // AXIS output to the MAC stage
    output logic                      m_axis_tvalid,
    output logic [DATA_WIDTH-1:0]     m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]   m_axis_tstrb,
    output logic                      m_axis_tlast,
    input  logic                      m_axis_tready
);

    localparam int BEATS  = 1 << BURST_LENGTH;
    localparam int DEPTH  = 1 << (BURST_LENGTH + 1);
    localparam int PTR_W  = BURST_LENGTH + 1;
    localparam int CNT_W  = BURST_LENGTH + 2;
    localparam int BLEN_W = BURST_LENGTH + 1;
    localparam int SIZE   = $clog2(DATA_WIDTH / 8);

    typedef enum logic [1:0] {S_IDLE, S_ARWAIT, S_ADDR, S_DATA} state_t;

    state_t              state_q, state_d;
    logic                rstart_q, rstart_d;
    logic [31:0]         addr_q, addr_d;
    logic [31:0]         remain_q, remain_d;
    logic                rerr_q, rerr_d;
    logic [BLEN_W-1:0]   outst_q, outst_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [DATA_WIDTH:0] mem_q [DEPTH];

    logic                start_edge;
    logic                r_hs;
    logic                t_hs;
    logic                fifo_empty;
    logic                credit;
    logic                beat_last;
    logic [BLEN_W-1:0]   blen;
    logic [CNT_W-1:0]    reserved;
    logic [CNT_W-1:0]    free_slots;
    logic                unused_ok;

    assign start_edge = RSTART_REG & ~rstart_q;
    assign fifo_empty = (count_q == '0);
    assign r_hs       = (state_q == S_DATA) & m_axi_rvalid;
    assign t_hs       = ~fifo_empty & m_axis_tready;
    assign blen       = (remain_q > 32'(BEATS)) ? BLEN_W'(BEATS) : remain_q[BLEN_W-1:0];
    // remain is already decremented at the AR handshake, so zero here means final burst
    assign beat_last  = m_axi_rlast & (remain_q == '0);

    // Space not yet promised to data: a full burst must fit before we ask for it
    assign reserved   = count_q + CNT_W'(outst_q);
    assign free_slots = CNT_W'(DEPTH) - reserved;
    assign credit     = (free_slots >= CNT_W'(BEATS));

    // Job sequencing: next state, address/length bookkeeping and error flag
    always_comb begin
        state_d  = state_q;
        rstart_d = RSTART_REG;
        addr_d   = addr_q;
        remain_d = remain_q;
        rerr_d   = rerr_q;
        outst_d  = outst_q;
        case (state_q)
            S_IDLE: begin
                if (start_edge) begin
                    addr_d   = RADDR_REG;
                    remain_d = RLENGTH_REG;
                    rerr_d   = 1'b0;
                    if (RLENGTH_REG != '0) begin
                        state_d = S_ARWAIT;
                    end
                end
            end
            S_ARWAIT: begin
                if (credit) begin
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (m_axi_arready) begin
                    addr_d   = addr_q + (32'(blen) << SIZE);
                    remain_d = remain_q - 32'(blen);
                    outst_d  = blen;
                    state_d  = S_DATA;
                end
            end
            S_DATA: begin
                if (m_axi_rvalid) begin
                    outst_d = outst_q - BLEN_W'(1);
                    if (m_axi_rresp != 2'b00) begin
                        rerr_d = 1'b1;
                    end
                    if (m_axi_rlast) begin
                        state_d = (remain_q == '0) ? S_IDLE : S_ARWAIT;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FIFO pointer and occupancy update; simultaneous push and pop cancel out
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(r_hs);
        rd_ptr_d = rd_ptr_q + PTR_W'(t_hs);
        count_d  = count_q + CNT_W'(r_hs) - CNT_W'(t_hs);
    end

    // State and FIFO control registers with synchronous active-low reset
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q  <= S_IDLE;
            rstart_q <= 1'b0;
            addr_q   <= '0;
            remain_q <= '0;
            rerr_q   <= 1'b0;
            outst_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            rstart_q <= rstart_d;
            addr_q   <= addr_d;
            remain_q <= remain_d;
            rerr_q   <= rerr_d;
            outst_q  <= outst_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // FIFO storage: data beat plus job-final flag; contents need no reset
    always_ff @(posedge aclk) begin
        if (r_hs) begin
            mem_q[wr_ptr_q] <= {beat_last, m_axi_rdata};
        end
    end

    assign m_axi_arid     = '0;
    assign m_axi_araddr   = addr_q;
    assign m_axi_arlen    = B_BURST_LENGTH'(blen - BLEN_W'(1));
    assign m_axi_arsize   = 3'(SIZE);
    assign m_axi_arburst  = 2'b01;
    assign m_axi_arlock   = 1'b0;
    assign m_axi_arcache  = 4'b0011;
    assign m_axi_arprot   = 3'b000;
    assign m_axi_arregion = 4'b0000;
    assign m_axi_arqos    = 4'b0000;
    assign m_axi_arvalid  = (state_q == S_ADDR);
    assign m_axi_rready   = (state_q == S_DATA);

    assign m_axis_tvalid  = ~fifo_empty;
    assign m_axis_tdata   = mem_q[rd_ptr_q][DATA_WIDTH-1:0];
    assign m_axis_tlast   = ~fifo_empty & mem_q[rd_ptr_q][DATA_WIDTH];
    assign m_axis_tstrb   = '1;

    assign RIDLE_REG      = (state_q == S_IDLE) & fifo_empty;
    assign RERR_REG       = rerr_q;

    // Only one burst is ever in flight, so the read ID carries no information
    assign unused_ok      = ^{m_axi_rid, 1'b0};

endmodule

// File: tb/tb_ddr_burst_reader.sv
// tb/tb_ddr_burst_reader.sv - directed table-driven bench for ddr_burst_reader
module tb_ddr_burst_reader;

    logic        aclk;
    logic        aresetn;
    logic        RSTART_REG;
    logic [31:0] RADDR_REG;
    logic [31:0] RLENGTH_REG;
    logic        RIDLE_REG;
    logic        RERR_REG;
    logic [0:0]  m_axi_arid;
    logic [31:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic        m_axi_arlock;
    logic [3:0]  m_axi_arcache;
    logic [2:0]  m_axi_arprot;
    logic [3:0]  m_axi_arregion;
    logic [3:0]  m_axi_arqos;
    logic        m_axi_arvalid;
    logic        m_axi_arready;
    logic [0:0]  m_axi_rid;
    logic [63:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rlast;
    logic        m_axi_rvalid;
    logic        m_axi_rready;
    logic        m_axis_tvalid;
    logic [63:0] m_axis_tdata;
    logic [7:0]  m_axis_tstrb;
    logic        m_axis_tlast;
    logic        m_axis_tready;

    ddr_burst_reader dut (
        .aclk(aclk), .aresetn(aresetn),
        .RSTART_REG(RSTART_REG), .RADDR_REG(RADDR_REG), .RLENGTH_REG(RLENGTH_REG),
        .RIDLE_REG(RIDLE_REG), .RERR_REG(RERR_REG),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
        .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arregion(m_axi_arregion),
        .m_axi_arqos(m_axi_arqos), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata), .m_axis_tstrb(m_axis_tstrb),
        .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] len;
        int          stall;
        int          err_beat;
        int          exp_nar;
        logic [7:0]  exp_last_len;
    } vec_t;

    int          n_chk = 0;
    int          n_pass = 0;
    logic        tready_en;
    logic [31:0] job_addr;
    int          job_len, job_err, exp_nar_g;
    logic [7:0]  exp_last_g;
    int          ar_n, ar_errs, proto_errs, rx_cnt, out_cnt, data_errs, last_cnt, first_bad;
    int          r_left;
    logic [31:0] r_addr;

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    function automatic logic [63:0] pat(input logic [31:0] a);
        return {a, ~a};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // One clock: drive slave/sink inputs on the falling edge, then account for the
    // handshakes that the coming rising edge will complete.
    task automatic step();
        logic [31:0] ea;
        logic [7:0]  el;
        @(negedge aclk);
        if (!aresetn) begin
            r_left       = 0;
            m_axi_rvalid = 1'b0;
            m_axi_rlast  = 1'b0;
        end else begin
            m_axi_rvalid = (r_left != 0);
            m_axi_rdata  = pat(r_addr);
            m_axi_rlast  = (r_left == 1);
            m_axi_rresp  = (rx_cnt == job_err) ? 2'b10 : 2'b00;
        end
        m_axis_tready = tready_en;
        if (aresetn) begin
            if (m_axi_rvalid && m_axi_rready) begin
                r_addr = r_addr + 32'd8;
                r_left--;
                rx_cnt++;
            end
            if (m_axi_arvalid && m_axi_arready) begin
                if (r_left != 0) proto_errs++;
                ea = job_addr + 32'(ar_n * 1024);
                el = (ar_n == exp_nar_g - 1) ? exp_last_g : 8'd127;
                if (m_axi_araddr !== ea || m_axi_arlen !== el) ar_errs++;
                r_addr = m_axi_araddr;
                r_left = int'(m_axi_arlen) + 1;
                ar_n++;
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (m_axis_tdata !== pat(job_addr + 32'(out_cnt * 8)) ||
                    m_axis_tlast !== (out_cnt == job_len - 1)) begin
                    if (data_errs == 0) first_bad = out_cnt;
                    data_errs++;
                end
                if (m_axis_tlast) last_cnt++;
                out_cnt++;
            end
        end
    endtask

    task automatic set_job(input vec_t v);
        job_addr = v.addr; job_len = int'(v.len); job_err = v.err_beat;
        exp_nar_g = v.exp_nar; exp_last_g = v.exp_last_len;
        ar_n = 0; ar_errs = 0; proto_errs = 0; rx_cnt = 0; out_cnt = 0;
        data_errs = 0; last_cnt = 0; first_bad = -1;
        RADDR_REG = v.addr; RLENGTH_REG = v.len;
    endtask

    task automatic run_job(input vec_t v, input string tag);
        int c;
        set_job(v);
        tready_en = (v.stall == 0);
        chk({tag, " ridle_pre"}, RIDLE_REG, 1);
        RSTART_REG = 1'b1;
        step();
        chk({tag, " arvalid_1cyc"}, m_axi_arvalid, 0);
        step();
        chk({tag, " arvalid_2cyc"}, m_axi_arvalid, v.len != 0);
        chk({tag, " ridle_busy"}, RIDLE_REG, v.len == 0);
        chk({tag, " rerr_clr"}, RERR_REG, 0);
        RSTART_REG = 1'b0;
        if (v.stall > 0) begin
            repeat (v.stall) step();
            chk({tag, " stall_ar_count"}, ar_n, 2);
            chk({tag, " stall_arvalid"}, m_axi_arvalid, 0);
            chk({tag, " stall_fifo_count"}, rx_cnt - out_cnt, 256);
            chk({tag, " stall_tvalid"}, m_axis_tvalid, 1);
            chk({tag, " stall_tdata"}, m_axis_tdata, pat(v.addr));
            chk({tag, " stall_tlast"}, m_axis_tlast, 0);
            tready_en = 1'b1;
        end
        c = 0;
        while (!RIDLE_REG && c < 4000) begin
            step();
            c++;
        end
        chk({tag, " finish_in_budget"}, c < 4000, 1);
        repeat (5) step();
        chk({tag, " ar_count"}, ar_n, v.exp_nar);
        chk({tag, " ar_addr_len_errs"}, ar_errs, 0);
        chk({tag, " overlapping_bursts"}, proto_errs, 0);
        chk({tag, " beat_count"}, out_cnt, v.len);
        if (data_errs != 0) $display("note %s first bad beat %0d", tag, first_bad);
        chk({tag, " beat_data_errs"}, data_errs, 0);
        chk({tag, " tlast_count"}, last_cnt, v.len != 0);
        chk({tag, " rerr_end"}, RERR_REG, v.err_beat >= 0);
        chk({tag, " ridle_end"}, RIDLE_REG, 1);
    endtask

    vec_t vecs[6];
    vec_t post;

    initial begin
        vecs[0] = '{32'h1000_0000,  128,   0, -1, 1, 8'd127};
        vecs[1] = '{32'h2000_0000,  300,   0, -1, 3, 8'd43};
        vecs[2] = '{32'h3000_0000,    0,   0, -1, 0, 8'd0};
        vecs[3] = '{32'h4000_0000, 1024, 400, -1, 8, 8'd127};
        vecs[4] = '{32'h5000_0000,   20,   0,  4, 1, 8'd19};
        vecs[5] = '{32'hFFFF_F800,  264,   0, -1, 3, 8'd7};
        post    = '{32'h7000_0000,   40,   0, -1, 1, 8'd39};

        aresetn = 1'b0; RSTART_REG = 1'b0; RADDR_REG = '0; RLENGTH_REG = '0;
        m_axi_arready = 1'b1; m_axi_rid = '0; m_axi_rdata = '0; m_axi_rresp = 2'b00;
        m_axi_rlast = 1'b0; m_axi_rvalid = 1'b0; tready_en = 1'b1; m_axis_tready = 1'b1;
        r_left = 0; r_addr = '0; job_err = -1; job_addr = '0; job_len = 0;
        exp_nar_g = 0; exp_last_g = '0;
        ar_n = 0; ar_errs = 0; proto_errs = 0; rx_cnt = 0; out_cnt = 0;
        data_errs = 0; last_cnt = 0; first_bad = -1;
        repeat (3) step();
        chk("rst arvalid", m_axi_arvalid, 0);
        chk("rst rready", m_axi_rready, 0);
        chk("rst tvalid", m_axis_tvalid, 0);
        chk("rst tlast", m_axis_tlast, 0);
        chk("rst ridle", RIDLE_REG, 1);
        chk("rst rerr", RERR_REG, 0);
        chk("const arsize_burst_cache", {m_axi_arsize, m_axi_arburst, m_axi_arcache}, {3'd3, 2'b01, 4'b0011});
        chk("const zeros", {m_axi_arid, m_axi_arlock, m_axi_arprot, m_axi_arregion, m_axi_arqos}, 0);
        chk("const tstrb", m_axis_tstrb, 8'hFF);
        aresetn = 1'b1;
        step();

        for (int i = 0; i < 6; i++) begin
            run_job(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset in the middle of a burst, after an error response has been seen
        begin
            vec_t v;
            int   c;
            v = '{32'h6000_0000, 128, 0, 2, 1, 8'd127};
            set_job(v);
            tready_en = 1'b1;
            RSTART_REG = 1'b1;
            step();
            RSTART_REG = 1'b0;
            c = 0;
            while (rx_cnt < 40 && c < 1000) begin
                step();
                c++;
            end
            chk("midrst reached_beat40", rx_cnt, 40);
            chk("midrst rerr_before", RERR_REG, 1);
            chk("midrst in_data", m_axi_rready, 1);
            aresetn = 1'b0;
            step();
            chk("midrst arvalid", m_axi_arvalid, 0);
            chk("midrst rready", m_axi_rready, 0);
            chk("midrst tvalid", m_axis_tvalid, 0);
            chk("midrst tlast", m_axis_tlast, 0);
            chk("midrst ridle", RIDLE_REG, 1);
            chk("midrst rerr", RERR_REG, 0);
            aresetn = 1'b1;
            step();
        end
        run_job(post, "post_reset");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
